// File: rtl/parity_frame_ctrl_pkg.sv
// Shared types for the parity frame controller: top-level FSM states and
// the parity accumulator's two states.
package parity_frame_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } par_t;

endpackage

// File: rtl/parity_frame_ctrl_if.sv
// Producer-side handshake, serial link beat and status signals of the
// parity frame controller. master = environment side, slave = controller side.
interface parity_frame_ctrl_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;
  logic              ser_ready;
  logic              ser_valid;
  logic              ser_out;
  logic              ser_last;
  logic              busy;
  logic              parity_out;

  modport master (
    output data_in, data_valid, ser_ready,
    input  data_ready, ser_valid, ser_out, ser_last, busy, parity_out
  );

  modport slave (
    input  data_in, data_valid, ser_ready,
    output data_ready, ser_valid, ser_out, ser_last, busy, parity_out
  );
endinterface

// File: rtl/parity_frame_ctrl_parity_acc.sv
// Running parity of the serialized payload, kept as an EVEN/ODD toggle FSM.
// clr has priority over en so an accept always starts a fresh frame.
module parity_acc
  import parity_frame_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic par
);

  par_t st, st_n;

  always_ff @(posedge clk) begin
    if (rst) st <= PAR_EVEN;
    else     st <= st_n;
  end

  always_comb begin
    st_n = st;
    if (clr)
      st_n = PAR_EVEN;
    else if (en && bit_in)
      st_n = (st == PAR_EVEN) ? PAR_ODD : PAR_EVEN;
  end

  assign par = (st == PAR_ODD);

endmodule

// File: rtl/parity_frame_ctrl.sv
// Frames a parallel word as LSB-first serial beats followed by a parity beat.
// Define ODD_PARITY_EN to emit odd parity instead of the default even parity.
module parity_frame_ctrl
  import parity_frame_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  parity_frame_ctrl_if.slave bus
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  state_t            state, state_n;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              acc_par;
  logic              par_bit;
  logic              parity_q;
  logic              accept;
  logic              beat;

  assign accept = bus.data_valid & bus.data_ready;
  assign beat   = (state == SHIFT) & bus.ser_ready;

`ifdef ODD_PARITY_EN
  assign par_bit = ~acc_par;
`else
  assign par_bit = acc_par;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Unused encodings fall back to IDLE on the next edge.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = SHIFT;
      SHIFT:   if (bus.ser_ready && (bit_cnt == LAST_IDX)) state_n = PARITY;
      PARITY:  if (bus.ser_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= '0;
      shreg    <= '0;
      parity_q <= 1'b0;
    end else begin
      if (accept) begin
        shreg   <= bus.data_in;
        bit_cnt <= '0;
      end else if (beat) begin
        shreg   <= shreg >> 1;
        bit_cnt <= bit_cnt + 1'b1;
      end
      if ((state == PARITY) && bus.ser_ready)
        parity_q <= par_bit;
    end
  end

  parity_acc u_acc (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .en     (beat),
    .bit_in (shreg[0]),
    .par    (acc_par)
  );

  assign bus.data_ready = (state == IDLE) & ~rst;
  assign bus.ser_valid  = (state == SHIFT) | (state == PARITY);
  assign bus.busy       = (state == SHIFT) | (state == PARITY);
  assign bus.ser_last   = (state == PARITY);
  assign bus.ser_out    = (state == SHIFT)  ? shreg[0] :
                          (state == PARITY) ? par_bit  : 1'b0;
  assign bus.parity_out = parity_q;

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Self-checking bench for parity_frame_ctrl: directed frames plus random words
// and random link back-pressure, compared against a bit-list parity model.
module tb_parity_frame_ctrl;
  import parity_frame_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  parity_frame_ctrl_if #(.DATA_W(8)) bus ();

  parity_frame_ctrl #(.DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic model_par(input logic [7:0] w);
    logic odd_ones;
    odd_ones = ($countones(w) % 2) == 1;
`ifdef ODD_PARITY_EN
    return ~odd_ones;
`else
    return odd_ones;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one frame from the current negedge and checks every beat.
  // abort_at >= 0 pulses rst while that payload beat is presented.
  task automatic run_frame(input logic [7:0] w, input bit hold, input int stall_pct,
                           input int stall_at, input int stall_len, input int abort_at);
    logic exp_beat[$];
    int   idx;
    int   guard;
    int   stalled;
    for (int i = 0; i < 8; i++) exp_beat.push_back(w[i]);
    exp_beat.push_back(model_par(w));

    bus.data_in    = w;
    bus.data_valid = 1'b1;
    guard = 0;
    while (bus.data_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("accept_wait", 32'(guard < 20), 1);
    if (guard >= 20) begin
      bus.data_valid = 1'b0;
      return;
    end
    @(negedge clk);
    if (!hold) begin
      bus.data_valid = 1'b0;
      bus.data_in    = 8'($urandom);
    end

    idx = 0; guard = 0; stalled = 0;
    while (idx < 9 && guard < 200) begin
      if (idx == abort_at) begin
        rst = 1'b1;
        bus.ser_ready = 1'b1;
        @(negedge clk);
        check("abort_valid", bus.ser_valid, 0);
        check("abort_last", bus.ser_last, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_ready_in_rst", bus.data_ready, 0);
        check("abort_parity_out", bus.parity_out, 0);
        rst = 1'b0;
        bus.data_valid = 1'b0;
        return;
      end
      check("beat_valid", bus.ser_valid, 1);
      check($sformatf("beat%0d_out", idx), bus.ser_out, exp_beat[idx]);
      check("beat_last", bus.ser_last, 32'(idx == 8));
      check("beat_busy", bus.busy, 1);
      check("beat_data_ready", bus.data_ready, 0);
      if (idx < 8) check("bit_cnt", 32'(dut.bit_cnt), idx);
      if (idx == stall_at && stalled < stall_len) begin
        bus.ser_ready = 1'b0;
        stalled++;
      end else begin
        bus.ser_ready = ($urandom_range(99) >= stall_pct);
      end
      @(negedge clk);
      guard++;
      if (bus.ser_ready) idx++;
    end
    check("beat_timeout", 32'(guard < 200), 1);
    check("parity_out", bus.parity_out, model_par(w));
    check("idle_valid", bus.ser_valid, 0);
    check("idle_last", bus.ser_last, 0);
    check("idle_ready", bus.data_ready, 1);
    bus.ser_ready = 1'b1;
  endtask

  initial begin
    rst            = 1'b1;
    bus.data_in    = '0;
    bus.data_valid = 1'b0;
    bus.ser_ready  = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ser_valid", bus.ser_valid, 0);
    check("rst_ser_last", bus.ser_last, 0);
    check("rst_ser_out", bus.ser_out, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_parity_out", bus.parity_out, 0);
    check("rst_data_ready", bus.data_ready, 0);
    rst = 1'b0;
    #1;
    check("post_rst_data_ready", bus.data_ready, 1);
    @(negedge clk);

    // Directed frames
    run_frame(8'hA5, 1'b0, 0, -1, 0, -1);
    run_frame(8'h07, 1'b0, 0, -1, 0, -1);
    run_frame(8'h00, 1'b0, 0, -1, 0, -1);
    run_frame(8'hA5, 1'b0, 0, 4, 3, -1);

    // Back-to-back with data_valid held: second accept on the first IDLE cycle
    run_frame(8'h3C, 1'b1, 0, -1, 0, -1);
    run_frame(8'hFF, 1'b0, 0, -1, 0, -1);

    // Reset mid-frame, then a fresh frame must not inherit partial parity
    run_frame(8'hFF, 1'b0, 0, -1, 0, 5);
    run_frame(8'h01, 1'b0, 0, -1, 0, -1);

    // Random words with random link back-pressure
    for (int n = 0; n < 20; n++)
      run_frame(8'($urandom), 1'b0, 30, -1, 0, -1);

    // Unused state encoding
    @(negedge clk);
    force dut.state = state_t'(2'd3);
    #1;
    check("illegal_ser_valid", bus.ser_valid, 0);
    check("illegal_busy", bus.busy, 0);
    check("illegal_data_ready", bus.data_ready, 0);
    release dut.state;
    @(negedge clk);
    check("illegal_recover_state", 32'(dut.state), 0);
    check("illegal_recover_ready", bus.data_ready, 1);
    check("illegal_recover_valid", bus.ser_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
